// File: rtl/dino_pkg.sv
// Shared player-state encodings and game-tick bit positions used by the player,
// renderer and game-control blocks.
package dino_pkg;

    localparam logic [2:0] PS_IDLE = 3'd0;
    localparam logic [2:0] PS_RUN  = 3'd1;
    localparam logic [2:0] PS_JUMP = 3'd2;
    localparam logic [2:0] PS_DUCK = 3'd3;
    localparam logic [2:0] PS_DEAD = 3'd4;

    localparam int TICK_VEL = 0;
    localparam int TICK_POS = 1;

    typedef enum logic [2:0] {
        S_IDLE = PS_IDLE,
        S_RUN  = PS_RUN,
        S_JUMP = PS_JUMP,
        S_DUCK = PS_DUCK,
        S_DEAD = PS_DEAD
    } player_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a hold counter; a new level is accepted once it has
// been stable for DEBOUNCE_CYCLES clocks, and o_rise flags the accepting cycle of a 0->1.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_count;
    logic          w_accept;

    // Accept on the edge the count would reach DEBOUNCE_CYCLES, so rise is usable that same edge.
    assign w_accept = (r_sync2 != r_level) && (r_count == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_level <= r_sync2;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = w_accept & r_sync2;

endmodule

// File: rtl/player_controller.sv
// Player control FSM: debounced buttons, tick-aligned jump requests to the physics block,
// landing/collision handling, restart holdoff and the run animation frame.
module player_controller
    import dino_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ANIM_DIV        = 4,
    parameter int DEAD_HOLDOFF    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_game_tick,
    input  logic       i_btn_up_raw,
    input  logic       i_btn_down_raw,
    input  logic       i_jump_done,
    input  logic       i_collision,
    output logic       o_jump_pulse,
    output logic       o_button_down,
    output logic [2:0] o_player_state,
    output logic [1:0] o_anim_frame,
    output logic       o_game_over
);

    localparam int AW = $clog2(ANIM_DIV + 1);
    localparam int HW = $clog2(DEAD_HOLDOFF + 1);

    player_state_e r_state;
    player_state_e w_next;
    logic          r_jump_req;
    logic [1:0]    r_anim_frame;
    logic [AW-1:0] r_anim_div;
    logic [HW-1:0] r_holdoff;

    logic w_up_level;
    logic w_up_rise;
    logic w_down_db;
    logic w_down_rise;
    logic w_unused;
    logic w_tick_vel;
    logic w_tick_pos;
    logic w_jump_pulse;
    logic w_holdoff_done;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (i_btn_up_raw),
        .o_level (w_up_level),
        .o_rise  (w_up_rise)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (i_btn_down_raw),
        .o_level (w_down_db),
        .o_rise  (w_down_rise)
    );

    assign w_unused       = w_up_level ^ w_down_rise;
    assign w_tick_vel     = i_game_tick[TICK_VEL];
    assign w_tick_pos     = i_game_tick[TICK_POS];
    assign w_holdoff_done = (r_holdoff == HW'(DEAD_HOLDOFF));
    // Holding down masks a pending jump so duck always wins over jump.
    assign w_jump_pulse   = w_tick_vel & (r_state == S_RUN) & r_jump_req & ~w_down_db;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_up_rise) w_next = S_RUN;
            S_RUN: begin
                if (i_collision)       w_next = S_DEAD;
                else if (w_jump_pulse) w_next = S_JUMP;
                else if (w_down_db)    w_next = S_DUCK;
            end
            S_JUMP: begin
                if (i_collision)                    w_next = S_DEAD;
                else if (w_tick_pos && i_jump_done) w_next = w_down_db ? S_DUCK : S_RUN;
            end
            S_DUCK: begin
                if (i_collision)    w_next = S_DEAD;
                else if (!w_down_db) w_next = S_RUN;
            end
            S_DEAD: if (w_up_rise && w_holdoff_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || r_state != S_RUN || w_next != S_RUN || w_down_db || w_jump_pulse) begin
            r_jump_req <= 1'b0;
        end else if (w_up_rise) begin
            r_jump_req <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || r_state != S_DEAD || w_next != S_DEAD) begin
            r_holdoff <= '0;
        end else if (w_tick_pos && !w_holdoff_done) begin
            r_holdoff <= r_holdoff + 1'b1;
        end
    end

    // The frame only advances while running or ducking; in the air it holds.
    always_ff @(posedge clk) begin
        if (!rst_n || w_next == S_IDLE || w_next == S_DEAD) begin
            r_anim_div   <= '0;
            r_anim_frame <= 2'd0;
        end else if (w_tick_pos && (r_state == S_RUN || r_state == S_DUCK)) begin
            if (r_anim_div == AW'(ANIM_DIV - 1)) begin
                r_anim_div   <= '0;
                r_anim_frame <= r_anim_frame + 2'd1;
            end else begin
                r_anim_div <= r_anim_div + 1'b1;
            end
        end
    end

    assign o_jump_pulse   = w_jump_pulse;
    assign o_button_down  = w_down_db & (r_state == S_RUN || r_state == S_JUMP || r_state == S_DUCK);
    assign o_player_state = r_state;
    assign o_anim_frame   = r_anim_frame;
    assign o_game_over    = (r_state == S_DEAD);

endmodule

// File: tb/tb_player_controller.sv
// Directed bench for player_controller with a free-running tick generator and a tiny
// stand-in for the physics block that lands three position ticks after each jump pulse.
module tb_player_controller;
    import dino_pkg::*;

    localparam int DB = 4;
    localparam int AD = 2;
    localparam int DH = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] gameTick = 2'b00;
    logic       btnUp = 1'b0;
    logic       btnDown = 1'b0;
    logic       collision = 1'b0;
    logic       jumpDone;
    logic       jumpPulse;
    logic       buttonDown;
    logic [2:0] playerState;
    logic [1:0] animFrame;
    logic       gameOver;

    int airTicks = 0;
    int phase = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign jumpDone = (airTicks == 1);

    player_controller #(
        .DEBOUNCE_CYCLES (DB),
        .ANIM_DIV        (AD),
        .DEAD_HOLDOFF    (DH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_game_tick    (gameTick),
        .i_btn_up_raw   (btnUp),
        .i_btn_down_raw (btnDown),
        .i_jump_done    (jumpDone),
        .i_collision    (collision),
        .o_jump_pulse   (jumpPulse),
        .o_button_down  (buttonDown),
        .o_player_state (playerState),
        .o_anim_frame   (animFrame),
        .o_game_over    (gameOver)
    );

    // Ticks alternate velocity/position every 4 clk; physics reacts to the pulse it saw.
    initial begin
        logic sawPulse;
        logic sawPos;
        forever begin
            @(negedge clk);
            sawPulse = jumpPulse;
            sawPos   = gameTick[1];
            @(posedge clk);
            #1;
            if (sawPulse) airTicks = 3;
            else if (sawPos && airTicks > 0) airTicks = airTicks - 1;
            phase = (phase + 1) % 8;
            gameTick = {phase == 7, phase == 3};
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic stepClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic up, input logic down, input int cycles);
        btnUp   = up;
        btnDown = down;
        stepClk(cycles);
    endtask

    task automatic waitState(input string tag, input logic [2:0] expState, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (playerState == expState) break;
            stepClk(1);
        end
        checkOutput(tag, playerState, expState);
    endtask

    task automatic waitPosTicks(input int n);
        int seen = 0;
        for (int i = 0; i < n * 8 + 8 && seen < n; i++) begin
            if (gameTick[1]) seen++;
            stepClk(1);
        end
    endtask

    initial begin
        int pulses;
        int misaligned;
        int found;

        rst_n = 1'b0;
        stepClk(3);
        checkOutput("rst_state", playerState, PS_IDLE);
        checkOutput("rst_pulse", jumpPulse, 0);
        checkOutput("rst_btn_down", buttonDown, 0);
        checkOutput("rst_game_over", gameOver, 0);
        checkOutput("rst_anim", animFrame, 0);
        rst_n = 1'b1;
        stepClk(2);

        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("glitch_idle", playerState, PS_IDLE);

        applyStimulus(1'b1, 1'b0, 5);
        checkOutput("start_pre", playerState, PS_IDLE);
        stepClk(1);
        checkOutput("start_run", playerState, PS_RUN);
        stepClk(4);
        applyStimulus(1'b0, 1'b0, 8);
        checkOutput("start_nojump", playerState, PS_RUN);

        btnUp = 1'b1;
        pulses = 0;
        misaligned = 0;
        for (int i = 0; i < 40; i++) begin
            stepClk(1);
            if (jumpPulse) begin
                pulses++;
                if (!gameTick[0]) misaligned++;
            end
            if (playerState == PS_JUMP) break;
        end
        btnUp = 1'b0;
        checkOutput("jump_pulses", pulses, 1);
        checkOutput("jump_aligned", misaligned, 0);
        checkOutput("jump_state", playerState, PS_JUMP);
        waitState("land_state", PS_RUN, 60);
        checkOutput("land_pos", airTicks, 0);

        stepClk(8);
        btnUp = 1'b1;
        btnDown = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            stepClk(1);
            if (jumpPulse) pulses++;
        end
        checkOutput("prio_duck", playerState, PS_DUCK);
        checkOutput("prio_btn_down", buttonDown, 1);
        btnUp = 1'b0;
        btnDown = 1'b0;
        for (int i = 0; i < 16; i++) begin
            stepClk(1);
            if (jumpPulse) pulses++;
        end
        checkOutput("prio_nopulse", pulses, 0);
        checkOutput("prio_run", playerState, PS_RUN);
        checkOutput("prio_btn_up", buttonDown, 0);

        btnUp = 1'b1;
        waitState("coll_jump", PS_JUMP, 40);
        btnUp = 1'b0;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            if (gameTick[1] && jumpDone) begin
                found = 1;
                break;
            end
            stepClk(1);
        end
        checkOutput("coll_found", found, 1);
        collision = 1'b1;
        stepClk(1);
        collision = 1'b0;
        checkOutput("coll_dead", playerState, PS_DEAD);
        checkOutput("coll_game_over", gameOver, 1);
        checkOutput("coll_btn_down", buttonDown, 0);

        waitPosTicks(1);
        applyStimulus(1'b1, 1'b0, 8);
        checkOutput("restart_early", playerState, PS_DEAD);
        applyStimulus(1'b0, 1'b0, 8);
        waitPosTicks(3);
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("restart_idle", playerState, PS_IDLE);
        checkOutput("restart_game_over", gameOver, 0);
        applyStimulus(1'b0, 1'b0, 8);
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("restart_run", playerState, PS_RUN);
        checkOutput("anim_start", animFrame, 0);

        btnUp = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            waitPosTicks(2);
            checkOutput($sformatf("anim_%0d", k), animFrame, k % 4);
        end

        stepClk(8);
        btnUp = 1'b1;
        waitState("rst_jump", PS_JUMP, 40);
        btnDown = 1'b1;
        stepClk(7);
        checkOutput("fastdrop_state", playerState, PS_JUMP);
        checkOutput("fastdrop_btn", buttonDown, 1);
        rst_n = 1'b0;
        stepClk(1);
        checkOutput("midrst_state", playerState, PS_IDLE);
        checkOutput("midrst_pulse", jumpPulse, 0);
        checkOutput("midrst_btn_down", buttonDown, 0);
        checkOutput("midrst_game_over", gameOver, 0);
        checkOutput("midrst_anim", animFrame, 0);
        rst_n = 1'b1;
        btnUp = 1'b0;
        btnDown = 1'b0;
        stepClk(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
